danger_spawner: RTL
===================

Name: danger_spawner

Overview:
- Produces the three obstacle slots consumed by the danger renderer: `new_danger_pos1..3`, `danger_type1..3` and `danger_en1..3`.
- Once per video frame it scrolls every active obstacle left by `speed` pixels and retires obstacles that leave the screen.
- It spawns new obstacles into free slots after an LFSR-randomised gap.
- It sits between the game-control FSM (`start`/`crash`/`speed`) and the renderer.

Parameters:
- SPAWN_X, 700, right-edge x position given to a freshly spawned obstacle (off-screen right of 640).
- INIT_GAP, 60, gap counter load value on entering RUN.
- MIN_GAP, 40, minimum frames between spawns; reload value = MIN_GAP + lfsr[5:0].
- SEED, 16'hACE1, LFSR reset value; a value of 0 is replaced by 16'h0001.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- frame_tick  in  1  one-cycle pulse, once per frame (during vertical blank).
- start  in  1  one-cycle pulse; starts or restarts the game.
- crash  in  1  one-cycle pulse; dino collided.
- speed  in  4  scroll pixels per frame; 0 means no motion.
- new_danger_pos1/2/3  out  10 each  obstacle right-edge x.
- danger_type1/2/3  out  3 each  0 LOW_BIRD, 1 HIGH_BIRD, 2 SMALL_CACTUS, 3 MANY_CACTUS, 4 BIG_CACTUS, 5 NOTHING.
- danger_en1/2/3  out  1 each  slot active.
- state  out  2  0 IDLE, 1 RUN, 2 OVER.

Behaviour:
- Reset (rst=0, asynchronous):
  - all pos = 0, all type = 5, all en = 0.
  - state = IDLE, gap_cnt = INIT_GAP, lfsr = SEED.
- Outputs: all registered. Updates triggered by a frame_tick take effect on the next clk edge (latency 1).
- FSM transitions:
  - IDLE→RUN on start.
  - RUN→OVER on crash.
  - OVER→RUN on start.
  - Any transition into RUN clears all slots (en=0, type=5, pos=0) and loads gap_cnt = INIT_GAP.
- FSM holds:
  - In IDLE and OVER, slots, gap_cnt and lfsr hold their values, so obstacles stay frozen on screen in OVER.
- Simultaneous events:
  - start and crash in the same cycle in RUN: crash wins.
  - start and frame_tick in the same cycle outside RUN: clear only, no movement.
  - start in RUN is ignored.
- LFSR: 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1. Advances exactly once per frame_tick while in RUN.
- RUN, per frame_tick, all evaluated on pre-tick register values:
  - Move: each slot with en=1 and pos > speed gets pos ← pos − speed (10-bit unsigned).
  - Retire: each slot with en=1 and pos ≤ speed gets en ← 0, type ← 5, pos ← 0.
  - Gap: if gap_cnt ≠ 0, then gap_cnt ← gap_cnt − 1 and no spawn.
  - Spawn: if gap_cnt = 0 and at least one slot has pre-tick en=0:
    - the lowest-index such slot gets en ← 1, pos ← SPAWN_X (not moved this tick) and type ← t;
    - t = lfsr[2:0] if < 5, else lfsr[2:0] − 3;
    - gap_cnt ← MIN_GAP + lfsr[5:0].
  - Full: if gap_cnt = 0 and no slot is free, gap_cnt stays 0. Spawn happens on the first later tick with a pre-tick free slot.
  - Retire/spawn overlap: a slot retired on a tick cannot be re-spawned on that same tick.
- Non-tick cycles in RUN change nothing.
- Reset mid-operation: immediate return to reset values regardless of state.

Test Plan:
1. Reset asserted → all en=0, type=5, pos=0, state=0; these hold through 10 frame_ticks with no start.
2. start, speed=4 → state=1. Ticks 1–60 give no spawn (gap_cnt 60→0). Tick 61 gives en1=1, pos1=700, type1 ∈ 0..4. After 10 more ticks pos1=660.
3. Slot at pos=3, speed=4 → next tick en=0, type=5, pos=0. With speed=0 the slot never moves and never retires.
4. All three slots en=1 and gap_cnt=0 → no spawn and gap_cnt stays 0. On the tick slot 2 retires, no spawn. On the following tick slot 2 spawns at 700.
5. crash during RUN → state=2; positions unchanged over 5 ticks. start → state=1, all slots cleared, first spawn 61 ticks later. start+crash in the same cycle in RUN → state=2.
6. rst pulled low mid-frame in RUN with slots active → outputs reach reset values without waiting for a clk edge. After release, the same stimulus reproduces an identical type sequence (same SEED).

Source files
------------

// File: rtl/danger_spawner.sv
// danger_spawner: owns the three obstacle slots drawn by the danger renderer.
// Once per frame (frame_tick) while the game runs, every active obstacle scrolls
// left by `speed` pixels, obstacles that reach the left edge are retired, and a
// new obstacle is spawned into the lowest free slot after an LFSR-randomised gap.
//
// Ports:
//   clk              system clock
//   rst              asynchronous active-low reset
//   frame_tick       one-cycle pulse per video frame
//   start            one-cycle pulse: start / restart the game
//   crash            one-cycle pulse: dino collided
//   speed            scroll pixels per frame (0 = frozen motion)
//   new_danger_pos*  obstacle right-edge x per slot
//   danger_type*     obstacle kind per slot (5 = nothing)
//   danger_en*       slot active
//   state            0 idle, 1 run, 2 over
module danger_spawner #(
  parameter int unsigned SPAWN_X  = 700,
  parameter int unsigned INIT_GAP = 60,
  parameter int unsigned MIN_GAP  = 40,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       crash,
  input  logic [3:0] speed,
  output logic [9:0] new_danger_pos1,
  output logic [9:0] new_danger_pos2,
  output logic [9:0] new_danger_pos3,
  output logic [2:0] danger_type1,
  output logic [2:0] danger_type2,
  output logic [2:0] danger_type3,
  output logic       danger_en1,
  output logic       danger_en2,
  output logic       danger_en3,
  output logic [1:0] state
);

  localparam int unsigned NumSlots = 3;
  localparam int unsigned GapW     = 8;
  // An all-zero LFSR would lock up, so a zero seed is nudged to 1.
  localparam logic [15:0] SeedInit = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [2:0]  TypeNone = 3'd5;
  localparam logic [9:0]  SpawnPos = 10'(SPAWN_X);
  localparam logic [GapW-1:0] GapInit = GapW'(INIT_GAP);
  localparam logic [GapW-1:0] GapMin  = GapW'(MIN_GAP);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StOver = 2'd2
  } state_e;

  state_e                        state_q, state_d;
  logic [NumSlots-1:0][9:0]      pos_q, pos_d;
  logic [NumSlots-1:0][2:0]      dtype_q, dtype_d;
  logic [NumSlots-1:0]           en_q, en_d;
  logic [GapW-1:0]               gap_q, gap_d;
  logic [15:0]                   lfsr_q, lfsr_d;

  logic       lfsr_fb;
  logic [2:0] spawn_type;
  logic [9:0] speed_ext;
  logic       spawn_done;

  // x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB.
  assign lfsr_fb    = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  // Fold 5..7 onto the cactus kinds 2..4 so every spawn is a real obstacle.
  assign spawn_type = (lfsr_q[2:0] < 3'd5) ? lfsr_q[2:0] : (lfsr_q[2:0] - 3'd3);
  assign speed_ext  = {6'd0, speed};

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    dtype_d    = dtype_q;
    en_d       = en_q;
    gap_d      = gap_q;
    lfsr_d     = lfsr_q;
    spawn_done = 1'b0;

    unique case (state_q)
      StIdle, StOver: begin
        // A coincident frame_tick is swallowed: entering the run only clears.
        if (start) begin
          state_d = StRun;
          en_d    = '0;
          pos_d   = '0;
          dtype_d = {NumSlots{TypeNone}};
          gap_d   = GapInit;
        end
      end
      StRun: begin
        if (crash) begin
          state_d = StOver;
        end else if (frame_tick) begin
          lfsr_d = {lfsr_q[14:0], lfsr_fb};

          for (int i = 0; i < NumSlots; i++) begin
            if (en_q[i]) begin
              if (pos_q[i] > speed_ext) begin
                pos_d[i] = pos_q[i] - speed_ext;
              end else begin
                en_d[i]    = 1'b0;
                dtype_d[i] = TypeNone;
                pos_d[i]   = '0;
              end
            end
          end

          if (gap_q != '0) begin
            gap_d = gap_q - GapW'(1);
          end else begin
            // Free means free before this tick, so a slot retiring now waits a tick.
            for (int i = 0; i < NumSlots; i++) begin
              if (!en_q[i] && !spawn_done) begin
                en_d[i]    = 1'b1;
                pos_d[i]   = SpawnPos;
                dtype_d[i] = spawn_type;
                spawn_done = 1'b1;
              end
            end
            // With every slot busy the gap stays at 0 so the next free slot fills at once.
            if (spawn_done) begin
              gap_d = GapMin + GapW'(lfsr_q[5:0]);
            end
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      pos_q   <= '0;
      dtype_q <= {NumSlots{TypeNone}};
      en_q    <= '0;
      gap_q   <= GapInit;
      lfsr_q  <= SeedInit;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      dtype_q <= dtype_d;
      en_q    <= en_d;
      gap_q   <= gap_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign new_danger_pos1 = pos_q[0];
  assign new_danger_pos2 = pos_q[1];
  assign new_danger_pos3 = pos_q[2];
  assign danger_type1    = dtype_q[0];
  assign danger_type2    = dtype_q[1];
  assign danger_type3    = dtype_q[2];
  assign danger_en1      = en_q[0];
  assign danger_en2      = en_q[1];
  assign danger_en3      = en_q[2];
  assign state           = state_q;

endmodule
